tick_div_ctrl: RTL and testbench

//  Run-time programmable tick scheduler wrapping a fixed-ratio divider (divide-by-N, 1-cycle pulse).

---
 rtl/tick_div_ctrl.sv | 83 ++++++++
 tb/tb_tick_div_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tick_div_ctrl.sv
// Programmable tick scheduler: a divide-by-N phase counter under a small
// IDLE/RUN controller. A config handshake loads the divisor and burst length.
// Periodic mode (burst 0) ticks forever. Burst mode emits K ticks, then pulses done.
module tick_div_ctrl #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 500,
  parameter int BST_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [BST_W-1:0] cfg_burst,
  input  logic             en,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] div_cur
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [BST_W-1:0] burst;
  logic [BST_W-1:0] tick_cnt;

  // A divisor of 0 or 1 cannot produce a 1-cycle pulse with a gap, so raise it to 2
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // Handshake and status flags are decoded straight from the state register
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // Controller, phase counter and pulse outputs; tick/done default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= CNT_W'(DEF_DIV);
      burst    <= '0;
      tick_cnt <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        // stop has no meaning while idle, so it does not block a new config
        if (cfg_valid) begin
          div_cur  <= clamp_div(cfg_div);
          burst    <= cfg_burst;
          cnt      <= '0;
          tick_cnt <= '0;
          state    <= RUN;
        end
      end else begin
        if (stop) begin
          // Abort takes priority over a terminal count in the same cycle
          state <= IDLE;
          cnt   <= '0;
        end else if (en) begin
          if (cnt == div_cur - CNT_W'(1)) begin
            cnt      <= '0;
            tick     <= 1'b1;
            tick_cnt <= tick_cnt + BST_W'(1);
            if ((burst != '0) && (tick_cnt == burst - BST_W'(1))) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_div_ctrl.sv
// Directed bench for tick_div_ctrl: periodic, burst, clamp, enable gating,
// abort and asynchronous reset, each with hand-computed expectations.
module tb_tick_div_ctrl;

  localparam int CNT_W = 16;
  localparam int BST_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [BST_W-1:0] cfg_burst;
  logic             en;
  logic             stop;
  logic             tick;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;

  int tests = 0;
  int fails = 0;
  int n;
  int m;

  tick_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(500), .BST_W(BST_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .en(en), .stop(stop),
    .tick(tick), .done(done), .busy(busy), .cnt(cnt), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance k rising edges and settle just after the last one
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until tick is seen high, bounded by lim
  task automatic wait_tick(input int lim, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!tick && edges < lim);
  endtask

  task automatic configure(input logic [CNT_W-1:0] d, input logic [BST_W-1:0] b);
    cfg_div   = d;
    cfg_burst = b;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_burst = '0; en = 1'b1; stop = 1'b0;
    step(2);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_div", div_cur, 500);
    rst = 1'b0;
    step(1);

    // 1: periodic divide-by-500
    configure(16'd500, 8'd0);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    chk("t1_cnt0", cnt, 0);
    wait_tick(510, n);
    chk("t1_first", n, 500);
    step(1);
    chk("t1_pulse1", tick, 0);
    wait_tick(510, n);
    chk("t1_second", n + 1, 500);
    chk("t1_ready_run", cfg_ready, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t1_stopped", busy, 0);

    // 2: burst of 3 with divisor 4
    configure(16'd4, 8'd3);
    wait_tick(10, n);
    chk("t2_tick1", n, 4);
    chk("t2_nodone1", done, 0);
    wait_tick(10, n);
    chk("t2_tick2", n, 4);
    wait_tick(10, n);
    chk("t2_tick3", n, 4);
    chk("t2_done", done, 1);
    chk("t2_busy_low", busy, 0);
    step(1);
    chk("t2_ready", cfg_ready, 1);
    chk("t2_done_pulse", done, 0);
    chk("t2_tick_pulse", tick, 0);
    chk("t2_cnt", cnt, 0);
    step(6);
    chk("t2_no_more", tick, 0);

    // 3: divisor clamp for 0 and 1
    configure(16'd0, 8'd0);
    chk("t3_div0", div_cur, 2);
    wait_tick(6, n);
    chk("t3_p0a", n, 2);
    wait_tick(6, n);
    chk("t3_p0b", n, 2);
    stop = 1'b1; step(1); stop = 1'b0;
    configure(16'd1, 8'd0);
    chk("t3_div1", div_cur, 2);
    wait_tick(6, n);
    chk("t3_p1", n, 2);
    stop = 1'b1; step(1); stop = 1'b0;

    // 4: enable gating stretches one period
    configure(16'd10, 8'd0);
    step(4);
    chk("t4_cnt4", cnt, 4);
    en = 1'b0;
    step(3);
    chk("t4_frozen", cnt, 4);
    chk("t4_notick", tick, 0);
    en = 1'b1;
    wait_tick(20, n);
    chk("t4_period", 7 + n, 13);
    wait_tick(20, n);
    chk("t4_next", n, 10);
    stop = 1'b1; step(1); stop = 1'b0;

    // 5: config ignored in RUN, stop at terminal count
    configure(16'd8, 8'd0);
    cfg_div = 16'd3; cfg_burst = 8'd1; cfg_valid = 1'b1;
    step(6);
    cfg_valid = 1'b0;
    step(1);
    chk("t5_cnt7", cnt, 7);
    chk("t5_div_kept", div_cur, 8);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t5_notick", tick, 0);
    chk("t5_idle", busy, 0);
    chk("t5_cnt0", cnt, 0);
    chk("t5_div_after", div_cur, 8);
    step(1);
    chk("t5_ready", cfg_ready, 1);

    // 6: stop+cfg in IDLE accepts; reset mid-burst
    stop = 1'b1;
    configure(16'd6, 8'd5);
    stop = 1'b0;
    chk("t6_accept", busy, 1);
    chk("t6_div", div_cur, 6);
    wait_tick(12, n);
    wait_tick(12, m);
    chk("t6_ticks", n + m, 12);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_tick", tick, 0);
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", cnt, 0);
    chk("t6_ready", cfg_ready, 1);
    chk("t6_div", div_cur, 500);
    step(1);
    rst = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
